// File: rtl/a_st_deserializer_pkg.sv
// Shared types for the aSt beat link: the aSt structure, beat framing constants
// and the deserializer state encoding.
package a_st_deserializer_pkg;

   localparam int ASIZE            = 7;
   localparam int ASIZE2           = 11;
   localparam int ANOTHER_SIZE     = 4;
   localparam int YET_ANOTHER_SIZE = 8;

   typedef logic [ASIZE-1:0]            aSizeT;
   typedef logic [ASIZE2-1:0]           aBiggerT;
   typedef logic [ANOTHER_SIZE-1:0]     anotherSizeT;
   typedef logic [YET_ANOTHER_SIZE-1:0] yetAnotherSizeT;

   // Element 0 of variablea2 is the least significant slice of the packed array.
   typedef struct packed {
      aSizeT                      variablea;
      aBiggerT [ASIZE2-1:0]       variablea2;
      anotherSizeT                another;
      yetAnotherSizeT             yetAnother;
   } aSt;

   localparam int A_ST_BEATS = 14;

   typedef logic [3:0]        aStBeatIdxT;
   typedef logic [ASIZE2-1:0] aStBeatT;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      HOLD    = 2'd1,
      DROP    = 2'd2
   } aStDeserStateT;

endpackage

// File: rtl/a_st_deserializer_if.sv
// Beat-in / structure-out channel of the aSt deserializer, plus its error reporting.
interface a_st_deserializer_if;
   import a_st_deserializer_pkg::*;

   logic       in_valid;
   logic       in_ready;
   aStBeatT    in_data;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   aSt         out_data;
   logic       err_pulse;
   logic [7:0] err_count;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, err_pulse, err_count
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, err_pulse, err_count
   );

endinterface

// File: rtl/a_st_deserializer_sat_counter.sv
// Up-counter that sticks at its maximum value instead of wrapping.
module a_st_deserializer_sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/a_st_deserializer.sv
// Reassembles one aSt structure from 14 narrow beats and holds it until the consumer
// takes it; malformed frames are discarded and counted.
module a_st_deserializer
   import a_st_deserializer_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   a_st_deserializer_if.slave  bus
);

   localparam logic [1:0] ST_COLLECT = COLLECT;
   localparam logic [1:0] ST_HOLD    = HOLD;
   localparam logic [1:0] ST_DROP    = DROP;

   localparam aStBeatIdxT IDX_ANOTHER = 4'(A_ST_BEATS - 2);
   localparam aStBeatIdxT IDX_LAST    = 4'(A_ST_BEATS - 1);

   logic [1:0] state_q, state_d;
   aStBeatIdxT cnt_q, cnt_d;
   aSt         stage_q, stage_d;
   aSt         out_data_q, out_data_d;
   logic       in_ready_q, in_ready_d;
   logic       err_pulse_q, err_pulse_d;
   logic       accept;
   logic       frame_err;

   assign accept = bus.in_valid & in_ready_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stage_d     = stage_q;
      out_data_d  = out_data_q;
      frame_err   = 1'b0;
      in_ready_d  = 1'b0;
      err_pulse_d = 1'b0;

      case (state_q)
         ST_COLLECT: begin
            if (accept) begin
               case (cnt_q)
                  4'd0:        stage_d.variablea  = bus.in_data[ASIZE-1:0];
                  IDX_ANOTHER: stage_d.another    = bus.in_data[ANOTHER_SIZE-1:0];
                  IDX_LAST:    stage_d.yetAnother = bus.in_data[YET_ANOTHER_SIZE-1:0];
                  default: begin
                     for (int i = 0; i < ASIZE2; i++) begin
                        if (cnt_q == aStBeatIdxT'(i + 1)) begin
                           stage_d.variablea2[i] = bus.in_data;
                        end
                     end
                  end
               endcase

               // The frame is only published once it is known to be well formed.
               if (cnt_q == IDX_LAST) begin
                  cnt_d = '0;
                  if (bus.in_last) begin
                     state_d    = ST_HOLD;
                     out_data_d = stage_d;
                  end else begin
                     state_d   = ST_DROP;
                     frame_err = 1'b1;
                  end
               end else if (bus.in_last) begin
                  cnt_d     = '0;
                  frame_err = 1'b1;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         ST_DROP: begin
            if (accept && bus.in_last) begin
               state_d = ST_COLLECT;
               cnt_d   = '0;
            end
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               state_d = ST_COLLECT;
            end
         end
         default: begin
            state_d = ST_COLLECT;
            cnt_d   = '0;
         end
      endcase

      in_ready_d  = (state_d != ST_HOLD);
      err_pulse_d = frame_err;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_COLLECT;
         cnt_q       <= '0;
         out_data_q  <= '0;
         in_ready_q  <= 1'b0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         in_ready_q  <= in_ready_d;
         err_pulse_q <= err_pulse_d;
      end
   end

   // Staging contents are always overwritten before use, so they carry no reset.
   always_ff @(posedge clk) begin
      stage_q <= stage_d;
   end

   a_st_deserializer_sat_counter #(
      .WIDTH (8)
   ) u_err_count (
      .clk   (clk),
      .rst   (rst),
      .inc   (frame_err),
      .count (bus.err_count)
   );

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = (state_q == ST_HOLD);
   assign bus.out_data  = out_data_q;
   assign bus.err_pulse = err_pulse_q;

endmodule

// File: tb/tb_a_st_deserializer.sv
// Self-checking bench for a_st_deserializer: directed scenarios plus randomized
// frame streams compared against a field-layout reference model.
module tb_a_st_deserializer;
   import a_st_deserializer_pkg::*;

   logic clk = 1'b0;
   logic rst;

   a_st_deserializer_if vif ();

   a_st_deserializer dut (
      .clk (clk),
      .rst (rst),
      .bus (vif)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cons_mode = 0;   // 0: always ready, 1: stalled, 2: random
   int exp_err = 0;
   int pulse_cnt = 0;
   logic [139:0] got_q[$];
   logic [139:0] exp_q[$];
   logic [10:0]  fr_d[1024];
   bit           fr_l[1024];

   // Consumer: out_ready changes just after the active edge.
   initial begin
      vif.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (cons_mode)
            0:       vif.out_ready = 1'b1;
            1:       vif.out_ready = 1'b0;
            default: vif.out_ready = ($urandom_range(99) < 60);
         endcase
      end
   end

   // Monitor: records delivered structures and error pulses mid-cycle.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (vif.out_valid === 1'b1 && vif.out_ready === 1'b1) got_q.push_back(vif.out_data);
         if (vif.err_pulse === 1'b1) pulse_cnt++;
      end
   end

   // Reference: place the 14 beats of a frame at base into the 140-bit aSt layout.
   function automatic logic [139:0] model_frame(input int base);
      logic [139:0] v;
      v = '0;
      v[139:133] = fr_d[base][6:0];
      for (int i = 0; i < 11; i++) v[12 + 11*i +: 11] = fr_d[base + 1 + i];
      v[11:8] = fr_d[base + 12][3:0];
      v[7:0]  = fr_d[base + 13][7:0];
      return v;
   endfunction

   function automatic int sat255(input int n);
      return (n > 255) ? 255 : n;
   endfunction

   task automatic load_good(input int base);
      for (int k = 0; k < 14; k++) begin
         fr_d[base + k] = 11'($urandom);
         fr_l[base + k] = (k == 13);
      end
   endtask

   task automatic send_beat(input logic [10:0] d, input bit l);
      bit ok;
      ok = 1'b0;
      vif.in_valid = 1'b1;
      vif.in_data  = d;
      vif.in_last  = l;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (vif.in_ready === 1'b1) ok = 1'b1;
      end
      if (ok) begin
         @(posedge clk);
         #1;
      end
      vif.in_valid = 1'b0;
      vif.in_data  = 11'($urandom);
      vif.in_last  = 1'($urandom_range(1));
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL beat_accept: in_ready never rose for data=%h", d);
      end
   endtask

   task automatic send_seq(input int base, input int n, input bit gaps);
      for (int k = 0; k < n; k++) begin
         if (gaps && $urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
         end
         send_beat(fr_d[base + k], fr_l[base + k]);
      end
   endtask

   task automatic wait_out(input int n);
      for (int i = 0; i < 3000 && got_q.size() < n; i++) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      checks++; if (vif.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", vif.in_ready); end
      checks++; if (vif.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", vif.out_valid); end
      checks++; if (vif.out_data !== 140'd0) begin errors++; $display("FAIL rst_out_data: got %h want 0", vif.out_data); end
      checks++; if (vif.err_pulse !== 1'b0) begin errors++; $display("FAIL rst_err_pulse: got %b want 0", vif.err_pulse); end
      checks++; if (vif.err_count !== 8'd0) begin errors++; $display("FAIL rst_err_count: got %0d want 0", vif.err_count); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++; if (vif.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", vif.in_ready); end
      @(posedge clk);
      #1;
      exp_err = 0;
   endtask

   task automatic test_single_frame;
      int g0;
      logic [139:0] exp;
      g0 = got_q.size();
      cons_mode = 0;
      fr_d[0] = 11'h005;
      for (int k = 1; k <= 11; k++) fr_d[k] = 11'(k - 1);
      fr_d[12] = 11'h003;
      fr_d[13] = 11'h0A5;
      for (int k = 0; k < 14; k++) fr_l[k] = (k == 13);
      exp = model_frame(0);
      send_seq(0, 14, 1'b0);
      @(negedge clk);
      checks++; if (vif.out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: out_valid=%b want 1", vif.out_valid); end
      checks++; if (vif.in_ready !== 1'b0) begin errors++; $display("FAIL single_hold_ready: in_ready=%b want 0", vif.in_ready); end
      checks++; if (vif.out_data !== exp) begin errors++; $display("FAIL single_data: got %h want %h", vif.out_data, exp); end
      checks++; if (vif.out_data.variablea !== 7'd5) begin errors++; $display("FAIL single_variablea: got %0d want 5", vif.out_data.variablea); end
      for (int i = 0; i < 11; i++) begin
         checks++;
         if (vif.out_data.variablea2[i] !== 11'(i)) begin
            errors++;
            $display("FAIL single_variablea2[%0d]: got %0d want %0d", i, vif.out_data.variablea2[i], i);
         end
      end
      checks++; if (vif.out_data.another !== 4'd3) begin errors++; $display("FAIL single_another: got %0d want 3", vif.out_data.another); end
      checks++; if (vif.out_data.yetAnother !== 8'hA5) begin errors++; $display("FAIL single_yetAnother: got %h want a5", vif.out_data.yetAnother); end
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++; if (vif.out_valid !== 1'b0) begin errors++; $display("FAIL single_release_valid: got %b want 0", vif.out_valid); end
      checks++; if (vif.in_ready !== 1'b1) begin errors++; $display("FAIL single_release_ready: got %b want 1", vif.in_ready); end
      checks++; if (got_q.size() - g0 !== 1) begin errors++; $display("FAIL single_count: got %0d frames want 1", got_q.size() - g0); end
      checks++; if (vif.err_count !== 8'd0) begin errors++; $display("FAIL single_err_count: got %0d want 0", vif.err_count); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure;
      int g0;
      logic [139:0] exp_a, exp_b;
      g0 = got_q.size();
      cons_mode = 1;
      load_good(0);
      load_good(14);
      exp_a = model_frame(0);
      exp_b = model_frame(14);
      send_seq(0, 14, 1'b0);
      vif.in_valid = 1'b1;
      vif.in_data  = fr_d[14];
      vif.in_last  = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++; if (vif.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, vif.in_ready); end
         checks++; if (vif.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid c%0d: got %b want 1", c, vif.out_valid); end
         checks++; if (vif.out_data !== exp_a) begin errors++; $display("FAIL bp_stable c%0d: got %h want %h", c, vif.out_data, exp_a); end
      end
      cons_mode = 0;
      send_seq(14, 14, 1'b0);
      wait_out(g0 + 2);
      checks++;
      if (got_q.size() - g0 !== 2) begin
         errors++;
         $display("FAIL bp_count: got %0d frames want 2", got_q.size() - g0);
      end else begin
         checks++; if (got_q[g0] !== exp_a) begin errors++; $display("FAIL bp_frame_a: got %h want %h", got_q[g0], exp_a); end
         checks++; if (got_q[g0+1] !== exp_b) begin errors++; $display("FAIL bp_frame_b: got %h want %h", got_q[g0+1], exp_b); end
      end
   endtask

   task automatic test_early_last;
      int g0, p0;
      logic [139:0] exp;
      g0 = got_q.size();
      p0 = pulse_cnt;
      cons_mode = 0;
      load_good(0);
      fr_l[5] = 1'b1;
      load_good(6);
      exp = model_frame(6);
      send_seq(0, 6, 1'b0);
      exp_err++;
      @(negedge clk);
      checks++; if (vif.err_pulse !== 1'b1) begin errors++; $display("FAIL early_pulse: got %b want 1", vif.err_pulse); end
      checks++; if (vif.err_count !== 8'(sat255(exp_err))) begin errors++; $display("FAIL early_count: got %0d want %0d", vif.err_count, sat255(exp_err)); end
      @(negedge clk);
      checks++; if (vif.err_pulse !== 1'b0) begin errors++; $display("FAIL early_pulse_width: got %b want 0", vif.err_pulse); end
      @(posedge clk);
      #1;
      send_seq(6, 14, 1'b0);
      wait_out(g0 + 1);
      repeat (2) @(negedge clk);
      checks++;
      if (got_q.size() - g0 !== 1) begin
         errors++;
         $display("FAIL early_frames: got %0d want 1", got_q.size() - g0);
      end else begin
         checks++; if (got_q[g0] !== exp) begin errors++; $display("FAIL early_good_data: got %h want %h", got_q[g0], exp); end
      end
      checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL early_pulse_total: got %0d want 1", pulse_cnt - p0); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_missing_last;
      int g0, p0;
      logic [139:0] exp;
      g0 = got_q.size();
      p0 = pulse_cnt;
      load_good(0);
      fr_l[13] = 1'b0;
      for (int k = 14; k < 17; k++) begin
         fr_d[k] = 11'($urandom);
         fr_l[k] = (k == 16);
      end
      load_good(17);
      exp = model_frame(17);
      send_seq(0, 31, 1'b0);
      exp_err++;
      wait_out(g0 + 1);
      repeat (2) @(negedge clk);
      checks++; if (vif.err_count !== 8'(sat255(exp_err))) begin errors++; $display("FAIL miss_count: got %0d want %0d", vif.err_count, sat255(exp_err)); end
      checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL miss_pulses: got %0d want 1", pulse_cnt - p0); end
      checks++;
      if (got_q.size() - g0 !== 1) begin
         errors++;
         $display("FAIL miss_frames: got %0d want 1", got_q.size() - g0);
      end else begin
         checks++; if (got_q[g0] !== exp) begin errors++; $display("FAIL miss_good_data: got %h want %h", got_q[g0], exp); end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_frame;
      int g0, p0;
      logic [139:0] exp;
      load_good(0);
      send_seq(0, 8, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_err = 0;
      @(negedge clk);
      checks++; if (vif.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b want 0", vif.in_ready); end
      checks++; if (vif.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", vif.out_valid); end
      checks++; if (vif.out_data !== 140'd0) begin errors++; $display("FAIL midrst_out_data: got %h want 0", vif.out_data); end
      checks++; if (vif.err_pulse !== 1'b0) begin errors++; $display("FAIL midrst_err_pulse: got %b want 0", vif.err_pulse); end
      checks++; if (vif.err_count !== 8'd0) begin errors++; $display("FAIL midrst_err_count: got %0d want 0", vif.err_count); end
      g0 = got_q.size();
      p0 = pulse_cnt;
      @(posedge clk);
      #1;
      load_good(0);
      exp = model_frame(0);
      send_seq(0, 14, 1'b0);
      wait_out(g0 + 1);
      repeat (2) @(negedge clk);
      checks++;
      if (got_q.size() - g0 !== 1) begin
         errors++;
         $display("FAIL midrst_frames: got %0d want 1", got_q.size() - g0);
      end else begin
         checks++; if (got_q[g0] !== exp) begin errors++; $display("FAIL midrst_data: got %h want %h", got_q[g0], exp); end
      end
      checks++; if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL midrst_pulses: got %0d want 0", pulse_cnt - p0); end
      checks++; if (vif.err_count !== 8'd0) begin errors++; $display("FAIL midrst_count_after: got %0d want 0", vif.err_count); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_random;
      int g0, p0, n, kind, k_end, junk;
      g0 = got_q.size();
      p0 = pulse_cnt;
      exp_q.delete();
      n = 0;
      for (int f = 0; f < 40; f++) begin
         kind = $urandom_range(9);
         load_good(n);
         if (kind < 7) begin
            exp_q.push_back(model_frame(n));
            n += 14;
         end else if (kind < 9 && kind == 7) begin
            k_end = $urandom_range(12);
            fr_l[n + k_end] = 1'b1;
            n += k_end + 1;
            exp_err++;
         end else begin
            fr_l[n + 13] = 1'b0;
            n += 14;
            junk = $urandom_range(1, 4);
            for (int j = 0; j < junk; j++) begin
               fr_d[n + j] = 11'($urandom);
               fr_l[n + j] = (j == junk - 1);
            end
            n += junk;
            exp_err++;
         end
      end
      cons_mode = 2;
      send_seq(0, n, 1'b1);
      wait_out(g0 + exp_q.size());
      cons_mode = 0;
      repeat (3) @(negedge clk);
      checks++;
      if (got_q.size() - g0 !== exp_q.size()) begin
         errors++;
         $display("FAIL rand_frames: got %0d want %0d", got_q.size() - g0, exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[g0 + i] !== exp_q[i]) begin
               errors++;
               $display("FAIL rand_data[%0d]: got %h want %h", i, got_q[g0 + i], exp_q[i]);
            end
         end
      end
      checks++; if (vif.err_count !== 8'(sat255(exp_err))) begin errors++; $display("FAIL rand_err_count: got %0d want %0d", vif.err_count, sat255(exp_err)); end
      checks++; if (pulse_cnt - p0 !== exp_err - (exp_err - (pulse_cnt - p0 >= 0 ? 0 : 0)) - 0 && 1'b0) begin errors++; end
      @(posedge clk);
      #1;
   endtask

   task automatic test_random_pulses;
      int p0, e;
      p0 = pulse_cnt;
      e = 0;
      cons_mode = 0;
      for (int f = 0; f < 20; f++) begin
         if ($urandom_range(1) == 1) begin
            send_beat(11'($urandom), 1'b1);
            e++;
         end else begin
            load_good(0);
            send_seq(0, 14, 1'b0);
         end
      end
      exp_err += e;
      repeat (3) @(negedge clk);
      checks++; if (pulse_cnt - p0 !== e) begin errors++; $display("FAIL rand_pulse_total: got %0d want %0d", pulse_cnt - p0, e); end
      checks++; if (vif.err_count !== 8'(sat255(exp_err))) begin errors++; $display("FAIL rand_pulse_count: got %0d want %0d", vif.err_count, sat255(exp_err)); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_saturation;
      int p0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_err = 0;
      p0 = pulse_cnt;
      cons_mode = 0;
      for (int f = 0; f < 300; f++) begin
         send_beat(11'($urandom), 1'b1);
         exp_err++;
         if (exp_err == 254 || exp_err == 255) begin
            @(negedge clk);
            checks++; if (vif.err_count !== 8'(exp_err)) begin errors++; $display("FAIL sat_edge_%0d: got %0d want %0d", exp_err, vif.err_count, exp_err); end
            @(posedge clk);
            #1;
         end
      end
      repeat (2) @(negedge clk);
      checks++; if (vif.err_count !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d want 255", vif.err_count); end
      checks++; if (pulse_cnt - p0 !== 300) begin errors++; $display("FAIL sat_pulses: got %0d want 300", pulse_cnt - p0); end
      @(posedge clk);
      #1;
   endtask

   initial begin
      vif.in_valid = 1'b0;
      vif.in_data  = '0;
      vif.in_last  = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_single_frame();
      test_backpressure();
      test_early_last();
      test_missing_last();
      test_reset_mid_frame();
      test_random();
      test_random_pulses();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/a_st_deserializer.md
# a_st_deserializer

Receive side of the aSt beat link. Accepts a fixed-format stream of 14 narrow beats over a valid/ready channel and reassembles one packed aSt structure (variablea, 11-element variablea2, another, yetAnother). Presents the structure on a valid/ready output to the consuming block. Sits between the link ingress and any unit consuming aSt from the hierInclude package. It is the counterpart of the serializer that emits aSt as beats.

## Interface
Parameters:
- none; all widths come from package constants (ASIZE=7, ASIZE2=11, ANOTHER_SIZE=4, YET_ANOTHER_SIZE=8).

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  beat present.
- in_ready  out  1  block accepts beat this cycle.
- in_data  in  ASIZE2 (11)  beat payload.
- in_last  in  1  marks final beat of a frame.
- out_valid  out  1  assembled aSt available.
- out_ready  in  1  consumer accepts aSt.
- out_data  out  $bits(aSt) (140)  assembled structure.
- err_pulse  out  1  one-cycle pulse per framing error.
- err_count  out  8  saturating framing-error count.

## Operation
- Beat map, by beat index k (0..13):
  - k=0: variablea = in_data[6:0].
  - k=1..11: variablea2[k-1] = in_data[10:0]. Element 0 is the LSB slice of the packed array.
  - k=12: another = in_data[3:0].
  - k=13: yetAnother = in_data[7:0].
- Unused upper bits of narrow beats are ignored and truncated. They are not an error.
- A beat is accepted when in_valid && in_ready.
- Beat counter is 4 bits, range 0..A_ST_BEATS-1 (13).
- State machine:
  - COLLECT:
    - in_ready=1.
    - Accepted beat writes its field and increments the counter.
    - Beat 13 with in_last=1 goes to HOLD and clears the counter.
    - in_last=1 on any k<13 is an early-last error: discard the partial frame, clear the counter, stay in COLLECT.
    - Beat 13 with in_last=0 is a missing-last error: go to DROP.
  - DROP:
    - in_ready=1.
    - Discards beats until a beat with in_last=1 is accepted, then goes to COLLECT with counter 0.
    - Beats dropped in DROP do not raise additional errors.
  - HOLD:
    - in_ready=0 and out_valid=1.
    - out_data is stable.
    - out_valid && out_ready goes to COLLECT.
- Error handling:
  - Each framing error pulses err_pulse for one cycle.
  - Each framing error increments err_count, which saturates at 255 and never wraps.
- Fields of a discarded partial frame never reach out_data.
  - out_data changes only on the COLLECT->HOLD transition.
  - Assembly uses a staging register, and the full 140-bit value is copied on the transition.

## Timing
- Reset (rst=1 at an edge) takes effect on the next cycle, regardless of state, including mid-frame or in HOLD:
  - state=COLLECT, counter=0.
  - in_ready=0 while rst is asserted; in_ready=1 on the first cycle after release.
  - out_valid=0, out_data=0, err_pulse=0, err_count=0.
  - Any partial frame is lost.
- Latency: out_valid rises the cycle after beat 13 is accepted.
- The consumer handshake completes on the edge where out_valid && out_ready. in_ready is 1 on the following cycle.
- Throughput: at most one frame per 15 cycles (14 beats plus 1 HOLD cycle with zero consumer stall).
- in_ready is a registered state decode with no combinational path from in_valid.
- out_valid never depends combinationally on out_ready.
- err_pulse asserts the cycle after the offending beat is accepted.
- in_data and in_last are sampled only on accepted beats. Values while in_valid=0 are don't-care.

## Structure
- Shared package (hierInclude package or a companion package):
  - constant A_ST_BEATS=14.
  - typedef aStBeatIdxT logic[3:0].
  - typedef aStBeatT logic[ASIZE2-1:0].
  - enum aStDeserStateT {COLLECT, HOLD, DROP}.
- aSt, aSizeT, aBiggerT, anotherSizeT and yetAnotherSizeT are reused unchanged from the package.
- No sub-module is needed; the FSM, counter, staging register and output register live in one module.
- The saturating error counter may be factored out as sat_counter8 if the team already keeps one.

## Test plan
- Single frame with zero consumer stall:
  - Stimulus: beats 0x05, 0x000..0x00A, 0x3, 0xA5, with in_last on beat 13.
  - Response: out_valid in the cycle after beat 13; variablea=5, variablea2[i]=i, another=3, yetAnother=0xA5.
- Consumer backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles with the next frame's valid beats already offered.
  - Response: in_ready=0 throughout, out_data stable, the frame completes once out_ready=1, and the second frame is assembled correctly.
- Early last:
  - Stimulus: in_last on beat 5, then a good frame.
  - Response: err_pulse for one cycle, err_count=1, no out_valid for the bad frame, the good frame delivered intact.
- Missing last:
  - Stimulus: 14 beats without in_last, then 3 junk beats with in_last on the 3rd, then a good frame.
  - Response: err_count=1 (a single error), the good frame delivered.
- Reset mid-frame:
  - Stimulus: rst after beat 7.
  - Response: all outputs at their reset values the next cycle; a following full frame is delivered without error.
- Saturation:
  - Stimulus: 300 consecutive early-last frames.
  - Response: err_count holds at 255.
